i2c_slave_rx_tx: RTL and testbench

- I2C target (responder) that answers the team's I2C master on the shared SCL/SDA bus.
- Oversamples SCL and SDA on the system clock and detects START and STOP conditions.
- Matches a 7-bit address; receives write bytes and returns read bytes through a simple byte interface.
- Drives SDA open-drain only (pull-low enable); never drives SCL (no clock stretching).

---
 rtl/i2c_slave_rx_tx.sv | 252 +++++++++++++++++++++++++
 tb/tb_i2c_slave_rx_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_rx_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_rx_tx
// Purpose  : I2C target that responds to one 7-bit address. SCL and SDA are
//            oversampled on clk, and the target detects START and STOP
//            conditions. Write bytes are delivered on rx_data/rx_valid. Read
//            bytes are requested with tx_req and taken from tx_data.
//            SDA is only ever pulled low (open drain). SCL is never driven,
//            so there is no clock stretching.
// Ports    : clk      - system clock, at least 8x the SCL frequency
//            rst_n    - asynchronous active-low reset
//            scl_in   - bus SCL level (asynchronous)
//            sda_in   - bus SDA level (asynchronous)
//            sda_oe   - 1 = pull SDA low, 0 = release
//            rx_data  - last byte written by the master
//            rx_valid - one-clk pulse when rx_data updates
//            tx_data  - byte returned on a read
//            tx_req   - one-clk pulse requesting tx_data for the next byte
//            busy     - high while this target is addressed
// Revision : 1.0 - initial release
// ============================================================================
module i2c_slave_rx_tx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_WRITE    = 3'd3,
        S_READ     = 3'd4,
        S_READ_ACK = 3'd5,
        S_IGNORE   = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers plus one history flop per line. They reset to 1
    // so that a reset looks like an idle bus and creates no false edges.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_prev <= r_scl_sync[SYNC_STAGES-1];
            r_sda_prev <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise =  w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl &  r_scl_prev;
    // SCL must be high in both samples, so an SDA edge that coincides with
    // an SCL transition is treated as a data change, not as START or STOP.
    assign w_start    = w_scl & r_scl_prev &  r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev &  w_sda;

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;    // received bits so far, or remaining read bits
    logic       r_rw;
    logic       r_ack;      // ACK-slot sub-phase within the current state

    logic [7:0] w_byte_in;
    logic       w_addr_hit;

    // The full byte is complete on the 8th rising edge of SCL.
    assign w_byte_in  = {r_shift, w_sda};
    // Address 0 (general call) is never accepted.
    assign w_addr_hit = (w_byte_in[7:1] == SLAVE_ADDR) && (w_byte_in[7:1] != 7'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 7'd0;
            r_rw      <= 1'b0;
            r_ack     <= 1'b0;
            sda_oe    <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;

            if (w_start) begin
                // A repeated START leaves busy alone until the new
                // address phase resolves.
                r_state   <= S_ADDR;
                sda_oe    <= 1'b0;
                r_bit_cnt <= 3'd0;
                r_ack     <= 1'b0;
            end else if (w_stop) begin
                r_state   <= S_IDLE;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                r_bit_cnt <= 3'd0;
                r_ack     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        sda_oe <= 1'b0;
                        busy   <= 1'b0;
                    end

                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte_in[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_rw <= w_sda;
                                if (w_addr_hit) begin
                                    r_state <= S_ADDR_ACK;
                                    r_ack   <= 1'b0;
                                end else begin
                                    r_state <= S_IGNORE;
                                    busy    <= 1'b0;
                                end
                            end
                        end
                    end

                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack) begin
                                // Start of the ACK clock.
                                sda_oe <= 1'b1;
                                busy   <= 1'b1;
                                tx_req <= r_rw;
                                r_ack  <= 1'b1;
                            end else if (r_rw) begin
                                r_state <= S_READ;
                                r_shift <= tx_data[6:0];
                                sda_oe  <= ~tx_data[7];
                                r_ack   <= 1'b0;
                            end else begin
                                r_state <= S_WRITE;
                                sda_oe  <= 1'b0;
                                r_ack   <= 1'b0;
                            end
                        end
                    end

                    S_WRITE: begin
                        if (!r_ack) begin
                            if (w_scl_rise) begin
                                r_shift   <= w_byte_in[6:0];
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                if (r_bit_cnt == 3'd7) begin
                                    rx_data  <= w_byte_in;
                                    rx_valid <= 1'b1;
                                    r_ack    <= 1'b1;
                                end
                            end
                        end else if (w_scl_fall) begin
                            // First fall drives the ACK. Second fall releases
                            // SDA and resumes data reception.
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                r_ack  <= 1'b0;
                            end
                        end
                    end

                    S_READ: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 3'd7) begin
                                sda_oe    <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                r_ack     <= 1'b0;
                                r_state   <= S_READ_ACK;
                            end else begin
                                sda_oe    <= ~r_shift[6];
                                r_shift   <= {r_shift[5:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end

                    S_READ_ACK: begin
                        if (!r_ack) begin
                            if (w_scl_rise) begin
                                if (!w_sda) begin
                                    tx_req <= 1'b1;
                                    r_ack  <= 1'b1;
                                end else begin
                                    r_state <= S_IGNORE;
                                    busy    <= 1'b0;
                                end
                            end
                        end else if (w_scl_fall) begin
                            r_state   <= S_READ;
                            r_shift   <= tx_data[6:0];
                            sda_oe    <= ~tx_data[7];
                            r_bit_cnt <= 3'd0;
                            r_ack     <= 1'b0;
                        end
                    end

                    S_IGNORE: begin
                        sda_oe <= 1'b0;
                        busy   <= 1'b0;
                    end

                    default: begin
                        r_state <= S_IDLE;
                        sda_oe  <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_rx_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_rx_tx
// Purpose  : Self-checking bench for i2c_slave_rx_tx. A bit-level bus master
//            drives SCL and SDA. A transaction-level model predicts the ACKs,
//            the received bytes, the read bit stream and the tx_req count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave_rx_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_m;
    logic       sda_m;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;

    always #5 clk = ~clk;

    // Open-drain bus: the line is low if either side pulls it low.
    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    i2c_slave_rx_tx #(
        .SLAVE_ADDR  (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    int         n_total = 0;
    int         n_bad   = 0;
    logic [7:0] got_rx[$];
    logic [7:0] exp_rx[$];
    int         tx_req_cnt = 0;
    logic [7:0] tb_bytes[4];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Record DUT pulses on the inactive clock edge.
    always @(negedge clk) begin
        if (rx_valid) got_rx.push_back(rx_data);
        if (tx_req) tx_req_cnt++;
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period of 16 clks. SDA is set mid-low and sampled mid-high.
    task automatic send_bit(input logic b, output logic s);
        sda_m = b;
        ticks(4);
        scl_m = 1'b1;
        ticks(4);
        s = sda_in;
        ticks(4);
        scl_m = 1'b0;
        ticks(4);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic coll);
        logic s;
        coll = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i], s);
            if (s !== d[i]) coll = 1'b1;
        end
    endtask

    task automatic recv_byte(output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
    endtask

    // START, or a repeated START when SCL is currently low.
    task automatic do_start();
        if (scl_m == 1'b0) begin
            sda_m = 1'b1;
            ticks(4);
            scl_m = 1'b1;
            ticks(4);
        end
        sda_m = 1'b0;
        ticks(4);
        scl_m = 1'b0;
        ticks(4);
    endtask

    task automatic do_stop();
        sda_m = 1'b0;
        ticks(4);
        scl_m = 1'b1;
        ticks(4);
        sda_m = 1'b1;
        ticks(6);
    endtask

    task automatic check_rx();
        int n;
        check_val("rx_count", got_rx.size(), exp_rx.size());
        n = (got_rx.size() < exp_rx.size()) ? got_rx.size() : exp_rx.size();
        for (int i = 0; i < n; i++) check_val("rx_byte", got_rx[i], exp_rx[i]);
        got_rx.delete();
        exp_rx.delete();
    endtask

    // Full transaction. Only the address decides the expected outcome:
    // the target ACKs everything when addressed and is silent otherwise.
    task automatic txn(input logic [6:0] addr, input logic rw, input int n, input bit stop);
        logic       exp_ack;
        logic       s;
        logic       coll;
        logic [7:0] b;
        int         req0;
        exp_ack = (addr == 7'h50);
        req0    = tx_req_cnt;
        if (rw) tx_data = tb_bytes[0];
        do_start();
        send_byte({addr, rw}, coll);
        check_val("addr_bus", coll, 0);
        send_bit(1'b1, s);
        check_val("addr_ack", s, !exp_ack);
        check_val("busy_addr", busy, exp_ack);
        for (int i = 0; i < n; i++) begin
            if (!rw) begin
                send_byte(tb_bytes[i], coll);
                check_val("wr_bus", coll, 0);
                send_bit(1'b1, s);
                check_val("wr_ack", s, !exp_ack);
                if (exp_ack) exp_rx.push_back(tb_bytes[i]);
            end else begin
                recv_byte(b);
                check_val("rd_byte", b, exp_ack ? tb_bytes[i] : 8'hFF);
                if (i + 1 < n) tx_data = tb_bytes[i + 1];
                send_bit((i == n - 1), s);
            end
        end
        if (rw) check_val("rd_release", sda_oe, 0);
        if (stop) begin
            do_stop();
            check_val("busy_stop", busy, 0);
        end
        check_val("tx_req_n", tx_req_cnt - req0, (exp_ack && rw) ? n : 0);
        check_rx();
    endtask

    initial begin
        logic s;
        logic coll;
        rst_n   = 1'b0;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        tx_data = 8'h00;
        ticks(5);
        check_val("rst_sda_oe", sda_oe, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_rx_valid", rx_valid, 0);
        check_val("rst_tx_req", tx_req, 0);
        check_val("rst_rx_data", rx_data, 8'h00);
        rst_n = 1'b1;
        ticks(10);

        // Write two bytes to the target.
        tb_bytes[0] = 8'hA5; tb_bytes[1] = 8'h3C;
        txn(7'h50, 1'b0, 2, 1'b1);
        check_val("wr_last", rx_data, 8'h3C);

        // Wrong address: no ACK and no data.
        tb_bytes[0] = 8'hFF;
        txn(7'h51, 1'b0, 1, 1'b1);

        // Read two bytes. The master NACKs the last one.
        tb_bytes[0] = 8'h96; tb_bytes[1] = 8'h0F;
        txn(7'h50, 1'b1, 2, 1'b1);

        // Write, then a repeated START into a read.
        tb_bytes[0] = 8'h12;
        txn(7'h50, 1'b0, 1, 1'b0);
        tb_bytes[0] = 8'hC3;
        txn(7'h50, 1'b1, 1, 1'b1);
        check_val("restart_rx", rx_data, 8'h12);

        // STOP after 4 data bits: the partial byte is dropped.
        tb_bytes[0] = 8'h77;
        txn(7'h50, 1'b0, 1, 1'b1);
        do_start();
        send_byte({7'h50, 1'b0}, coll);
        send_bit(1'b1, s);
        check_val("part_addr_ack", s, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, s);
        do_stop();
        check_val("part_busy", busy, 0);
        check_val("part_rx_data", rx_data, 8'h77);
        check_rx();

        // Reset in the middle of a write data bit.
        do_start();
        send_byte({7'h50, 1'b0}, coll);
        send_bit(1'b1, s);
        for (int i = 0; i < 3; i++) send_bit(1'b0, s);
        sda_m = 1'b1;
        ticks(4);
        scl_m = 1'b1;
        ticks(2);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_sda_oe", sda_oe, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_rx_valid", rx_valid, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        ticks(4);
        rst_n = 1'b1;
        ticks(4);
        got_rx.delete();
        tb_bytes[0] = 8'h5A;
        txn(7'h50, 1'b0, 1, 1'b1);

        // Randomised transactions, some of which chain through repeated STARTs.
        for (int k = 0; k < 20; k++) begin
            logic [6:0] a;
            logic       rw;
            int         n;
            bit         st;
            a  = ($urandom_range(0, 1) == 1) ? 7'h50 : 7'($urandom_range(0, 127));
            rw = 1'($urandom_range(0, 1));
            n  = $urandom_range(1, 3);
            st = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) tb_bytes[i] = 8'($urandom_range(0, 255));
            txn(a, rw, n, st);
        end
        if (scl_m == 1'b0) begin
            do_stop();
            check_val("final_busy", busy, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
